// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serves, point freezes, pause, scoring and winner detection.
// All delays are counted in video frames so they are independent of pixel clock.
module pong_game_ctrl #(
    parameter int unsigned WIN_SCORE    = 11,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 90,
    parameter int unsigned SCORE_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               frame_tick,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               game_on,
    output logic               ball_serve,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    localparam int unsigned MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int unsigned CNT_W      = $clog2(MAX_FRAMES) + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_POINT  = 3'd3,
        ST_PAUSED = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    state_t             st;
    logic [CNT_W-1:0]   frame_cnt;
    logic               start_q;
    logic               pause_q;
    logic               start_edge;
    logic               pause_edge;
    logic               serve_done;
    logic               point_done;
    logic               left_won;
    logic               right_won;

    assign start_edge = start & ~start_q;
    assign pause_edge = pause & ~pause_q;
    assign serve_done = frame_tick && (frame_cnt == CNT_W'(SERVE_FRAMES - 1));
    assign point_done = frame_tick && (frame_cnt == CNT_W'(POINT_FRAMES - 1));
    assign left_won   = (score_left  == SCORE_W'(WIN_SCORE));
    assign right_won  = (score_right == SCORE_W'(WIN_SCORE));
    assign state      = st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st          <= ST_IDLE;
            frame_cnt   <= '0;
            start_q     <= 1'b0;
            pause_q     <= 1'b0;
            game_on     <= 1'b0;
            ball_serve  <= 1'b0;
            serve_dir   <= 1'b0;
            score_left  <= '0;
            score_right <= '0;
            winner      <= 2'd0;
        end else begin
            start_q    <= start;
            pause_q    <= pause;
            ball_serve <= 1'b0;
            case (st)
                ST_IDLE, ST_OVER: begin
                    if (start_edge) begin
                        st          <= ST_SERVE;
                        frame_cnt   <= '0;
                        game_on     <= 1'b1;
                        serve_dir   <= 1'b0;
                        score_left  <= '0;
                        score_right <= '0;
                        winner      <= 2'd0;
                    end
                end
                ST_SERVE: begin
                    if (serve_done) begin
                        st         <= ST_PLAY;
                        frame_cnt  <= '0;
                        ball_serve <= 1'b1;
                    end else if (frame_tick) begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                    end
                end
                ST_PLAY: begin
                    // A miss always takes priority over a coincident pause press
                    if (miss_left || miss_right) begin
                        st        <= ST_POINT;
                        frame_cnt <= '0;
                        game_on   <= 1'b0;
                        if (miss_left && !miss_right) begin
                            serve_dir <= 1'b0;
                            if (!right_won) score_right <= score_right + SCORE_W'(1);
                        end else if (miss_right && !miss_left) begin
                            serve_dir <= 1'b1;
                            if (!left_won) score_left <= score_left + SCORE_W'(1);
                        end
                    end else if (pause_edge) begin
                        st        <= ST_PAUSED;
                        frame_cnt <= '0;
                        game_on   <= 1'b0;
                    end
                end
                ST_POINT: begin
                    if (point_done) begin
                        frame_cnt <= '0;
                        if (left_won) begin
                            st     <= ST_OVER;
                            winner <= 2'd1;
                        end else if (right_won) begin
                            st     <= ST_OVER;
                            winner <= 2'd2;
                        end else begin
                            st      <= ST_SERVE;
                            game_on <= 1'b1;
                        end
                    end else if (frame_tick) begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                    end
                end
                ST_PAUSED: begin
                    if (pause_edge) begin
                        st        <= ST_PLAY;
                        frame_cnt <= '0;
                        game_on   <= 1'b1;
                    end
                end
                default: begin
                    st        <= ST_IDLE;
                    frame_cnt <= '0;
                    game_on   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with WIN_SCORE=3, SERVE_FRAMES=4, POINT_FRAMES=3.
module tb_pong_game_ctrl;

    localparam int unsigned WIN_SCORE    = 3;
    localparam int unsigned SERVE_FRAMES = 4;
    localparam int unsigned POINT_FRAMES = 3;
    localparam int unsigned SCORE_W      = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               pause = 1'b0;
    logic               frame_tick = 1'b0;
    logic               miss_left = 1'b0;
    logic               miss_right = 1'b0;
    logic               game_on;
    logic               ball_serve;
    logic               serve_dir;
    logic [SCORE_W-1:0] score_left;
    logic [SCORE_W-1:0] score_right;
    logic [1:0]         winner;
    logic [2:0]         state;

    int n_vec = 0;
    int n_err = 0;

    pong_game_ctrl #(
        .WIN_SCORE    (WIN_SCORE),
        .SERVE_FRAMES (SERVE_FRAMES),
        .POINT_FRAMES (POINT_FRAMES),
        .SCORE_W      (SCORE_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .frame_tick  (frame_tick),
        .miss_left   (miss_left),
        .miss_right  (miss_right),
        .game_on     (game_on),
        .ball_serve  (ball_serve),
        .serve_dir   (serve_dir),
        .score_left  (score_left),
        .score_right (score_right),
        .winner      (winner),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given pulses; outputs are sampled 1 ns after the edge
    task automatic step(input logic ft, input logic ml, input logic mr);
        frame_tick = ft;
        miss_left  = ml;
        miss_right = mr;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        start = 1'b0;
    endtask

    task automatic check_scores(input string tag, input int l, input int r);
        check({tag, "_score_left"}, int'(score_left), l);
        check({tag, "_score_right"}, int'(score_right), r);
    endtask

    // From SERVE entry: launch happens on the 4th tick, then PLAY
    task automatic serve_seq(input string tag, input int dir);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check({tag, "_no_serve_yet"}, int'(ball_serve), 0);
        end
        check({tag, "_still_serve"}, int'(state), 1);
        step(1'b1, 1'b0, 1'b0);
        check({tag, "_ball_serve"}, int'(ball_serve), 1);
        check({tag, "_serve_dir"}, int'(serve_dir), dir);
        check({tag, "_to_play"}, int'(state), 2);
        step(1'b0, 1'b0, 1'b0);
        check({tag, "_serve_pulse_end"}, int'(ball_serve), 0);
        check({tag, "_play_game_on"}, int'(game_on), 1);
    endtask

    // From POINT entry: three ticks end the freeze
    task automatic point_wait(input string tag, input int next_state);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check({tag, "_point_hold"}, int'(state), 3);
        step(1'b1, 1'b0, 1'b0);
        check({tag, "_after_point"}, int'(state), next_state);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", int'(state), 0);
        check("rst_game_on", int'(game_on), 0);
        check("rst_ball_serve", int'(ball_serve), 0);
        check("rst_winner", int'(winner), 0);
        check_scores("rst", 0, 0);
        reset = 1'b0;

        step(1'b1, 1'b1, 1'b1);
        check("idle_ignores", int'(state), 0);

        press_start();
        check("start_state", int'(state), 1);
        check("start_game_on", int'(game_on), 1);
        serve_seq("serve1", 0);

        press_start();
        check("start_in_play_ignored", int'(state), 2);

        step(1'b0, 1'b1, 1'b0);
        check("ml_state", int'(state), 3);
        check("ml_game_on", int'(game_on), 0);
        check("ml_dir", int'(serve_dir), 0);
        check_scores("ml", 0, 1);
        point_wait("ml", 1);
        check("ml_resume_game_on", int'(game_on), 1);
        serve_seq("serve2", 0);

        step(1'b0, 1'b0, 1'b1);
        check("mr_dir", int'(serve_dir), 1);
        check_scores("mr", 1, 1);
        point_wait("mr", 1);
        serve_seq("serve3", 1);

        step(1'b0, 1'b1, 1'b1);
        check("both_state", int'(state), 3);
        check("both_dir", int'(serve_dir), 1);
        check_scores("both", 1, 1);
        point_wait("both", 1);
        serve_seq("serve4", 1);

        pause = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("pause_state", int'(state), 4);
        check("pause_game_on", int'(game_on), 0);
        step(1'b1, 1'b1, 1'b0);
        check("pause_miss_state", int'(state), 4);
        check_scores("pause_miss", 1, 1);
        pause = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        check("pause_release_no_edge", int'(state), 4);
        pause = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("unpause_state", int'(state), 2);
        check("unpause_no_serve", int'(ball_serve), 0);
        check("unpause_game_on", int'(game_on), 1);
        pause = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        pause = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        pause = 1'b0;
        check("pause_vs_miss_state", int'(state), 3);
        check_scores("pause_vs_miss", 2, 1);
        point_wait("pvm", 1);
        serve_seq("serve5", 1);

        step(1'b0, 1'b0, 1'b1);
        check_scores("win_point", 3, 1);
        point_wait("win", 5);
        check("win_winner", int'(winner), 1);
        check("win_game_on", int'(game_on), 0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check("over_hold_state", int'(state), 5);
        check_scores("over_hold", 3, 1);
        check("over_hold_winner", int'(winner), 1);

        press_start();
        check("restart_state", int'(state), 1);
        check("restart_winner", int'(winner), 0);
        check("restart_dir", int'(serve_dir), 0);
        check_scores("restart", 0, 0);
        serve_seq("serve6", 0);
        step(1'b0, 1'b1, 1'b0);
        point_wait("pre_rst", 1);
        serve_seq("serve7", 0);
        check_scores("pre_rst", 0, 1);

        #2 reset = 1'b1;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_game_on", int'(game_on), 0);
        check_scores("async_rst", 0, 0);
        @(posedge clk);
        #1;
        check("async_rst_ball_serve", int'(ball_serve), 0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
